// File: rtl/regfile_param.sv
// Parametrised two-read/two-write register file with a post-reset clear sweep,
// optional same-cycle write bypass and optional hardwired zero register.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] WriteReg1,
    input  logic [DATA_W-1:0] WriteData1,
    input  logic              RegWrite1,
    input  logic [ADDR_W-1:0] WriteReg2,
    input  logic [DATA_W-1:0] WriteData2,
    input  logic              RegWrite2,
    output logic              Ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run_we1, run_we2;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = ready_q;
        if (state_q == CLEAR) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_d = RUN;
                ready_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
        end
    end

    // Address 0 drops writes when hardwired to zero.
    assign run_we1 = RegWrite1 && !((ZERO_REG != 0) && (WriteReg1 == '0));
    assign run_we2 = RegWrite2 && !((ZERO_REG != 0) && (WriteReg2 == '0));

    // NOTE: the array has no reset branch; the clear sweep zeroes it so it can map onto plain RAM/flops without reset.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[ptr_q] <= '0;
            end else begin
                if (run_we1) mem[WriteReg1] <= WriteData1;
                // Port 2 is assigned last so it wins on an address collision.
                if (run_we2) mem[WriteReg2] <= WriteData2;
            end
        end
    end

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (state_q == RUN) begin
            if ((ZERO_REG != 0) && (ReadReg1 == '0))
                ReadData1 = '0;
            else if ((BYPASS != 0) && RegWrite2 && (WriteReg2 == ReadReg1))
                ReadData1 = WriteData2;
            else if ((BYPASS != 0) && RegWrite1 && (WriteReg1 == ReadReg1))
                ReadData1 = WriteData1;
            else
                ReadData1 = mem[ReadReg1];

            if ((ZERO_REG != 0) && (ReadReg2 == '0))
                ReadData2 = '0;
            else if ((BYPASS != 0) && RegWrite2 && (WriteReg2 == ReadReg2))
                ReadData2 = WriteData2;
            else if ((BYPASS != 0) && RegWrite1 && (WriteReg1 == ReadReg2))
                ReadData2 = WriteData1;
            else
                ReadData2 = mem[ReadReg2];
        end
    end

    assign Ready = ready_q;

endmodule
